// File: rtl/dmem_store_drain_pkg.sv
// Shared types, widths and load/store helpers for the MEM-stage store-drain block.
package dmem_store_drain_pkg;

   localparam int PREG_W = 6;
   localparam int ROB_W  = 5;
   localparam int WIDX_W = 30;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [2:0] F3_LW     = 3'b010;
   localparam logic [2:0] F3_LBU    = 3'b100;
   localparam logic [2:0] F3_SW     = 3'b010;
   localparam logic [2:0] F3_SH     = 3'b001;

   // Buffered store; sh data is already replicated into both halfword lanes
   typedef struct packed {
      logic              valid;
      logic [WIDX_W-1:0] word_idx;
      logic [31:0]       data;
      logic              sh;
      logic [1:0]        byte_off;
   } sb_entry_t;

   // sw_sh_signal: 1'b0 = sw, 1'b1 = sh
   typedef struct packed {
      logic [31:0]      addr;
      logic [31:0]      ps2_data;
      logic             sw_sh_signal;
      logic [ROB_W-1:0] rob_tag;
   } lsq_entry_t;

   typedef struct packed {
      logic [31:0]       pc;
      logic [PREG_W-1:0] pd;
      logic [ROB_W-1:0]  rob_index;
      logic [2:0]        func3;
   } rs_data_t;

   function automatic logic [31:0] load_format(input logic [2:0] func3,
                                               input logic [31:0] word,
                                               input logic [1:0] off);
      logic [31:0] res;
      case (func3)
         F3_LW:   res = word;
         F3_LBU:  res = {24'd0, word[{off, 3'b000} +: 8]};
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] store_lanes(input logic sh, input logic off_hi);
      logic [3:0] be;
      if (!sh) begin
         be = 4'b1111;
      end else if (off_hi) begin
         be = 4'b1100;
      end else begin
         be = 4'b0011;
      end
      return be;
   endfunction

   function automatic logic fwd_covers(input logic ent_sh, input logic ent_hi,
                                       input logic [2:0] func3, input logic ld_hi);
      logic ok;
      case (func3)
         F3_LW:   ok = !ent_sh;
         F3_LBU:  ok = !ent_sh || (ent_hi == ld_hi);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_store_drain_ram.sv
// Word-organised data RAM: one byte-enabled write port and one synchronous read port.
module dmem_store_drain_ram #(
   parameter  int MEM_WORDS = 256,
   localparam int AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    wbe,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [MEM_WORDS];

   // Byte-lane write of drained store data
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // Synchronous read for accepted loads
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/dmem_store_drain.sv
// In-order store buffer draining into the data RAM, plus the one-cycle load responder.
// Optional store-to-load forwarding is built when SB_FWD_EN is defined.
module dmem_store_drain
   import dmem_store_drain_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int SB_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              store_wb,
   input  lsq_entry_t        store_in,
   input  logic              load_req,
   input  rs_data_t          load_in,
   input  logic [31:0]       load_addr,
   output logic              load_ready,
   output logic              ld_done,
   output logic [31:0]       ld_data,
   output logic [PREG_W-1:0] ld_pd,
   output logic [ROB_W-1:0]  ld_rob_tag,
   output logic              sb_full,
   output logic              sb_empty
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;

   sb_entry_t         sb_r [SB_DEPTH];
   logic [PW-1:0]     head_r;
   logic [PW-1:0]     tail_r;
   logic [CW-1:0]     count_r;

   logic [WIDX_W-1:0] st_widx_s;
   logic [WIDX_W-1:0] ld_widx_s;
   sb_entry_t         push_entry_s;
   sb_entry_t         head_entry_s;
   sb_entry_t         hit_entry_s;
   logic              hit_s;
   logic              fwd_s;
   logic              load_acc_s;
   logic              push_s;
   logic              pop_s;
   logic [3:0]        wbe_s;
   logic [31:0]       rdata_s;

   logic              ld_fwd_r;
   logic [31:0]       fwd_data_r;
   logic [2:0]        ld_f3_r;
   logic [1:0]        ld_off_r;

   assign st_widx_s    = WIDX_W'(store_in.addr[AW+1:2]);
   assign ld_widx_s    = WIDX_W'(load_addr[AW+1:2]);
   assign head_entry_s = sb_r[head_r];
   assign sb_full      = (count_r == CW'(SB_DEPTH));
   assign sb_empty     = (count_r == {CW{1'b0}});

   // Incoming store formatted as a buffer entry
   always_comb begin
      push_entry_s          = '0;
      push_entry_s.valid    = 1'b1;
      push_entry_s.word_idx = st_widx_s;
      push_entry_s.data     = store_in.sw_sh_signal ? {2{store_in.ps2_data[15:0]}}
                                                    : store_in.ps2_data;
      push_entry_s.sh       = store_in.sw_sh_signal;
      push_entry_s.byte_off = store_in.addr[1:0];
   end

   // Youngest buffered (or same-cycle incoming) store to the load's word
   always_comb begin
      hit_s       = 1'b0;
      hit_entry_s = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (sb_r[head_r + PW'(i)].valid && (sb_r[head_r + PW'(i)].word_idx == ld_widx_s)) begin
            hit_s       = 1'b1;
            hit_entry_s = sb_r[head_r + PW'(i)];
         end else begin
            hit_s = hit_s;
         end
      end
      if (store_wb && (push_entry_s.word_idx == ld_widx_s)) begin
         hit_s       = 1'b1;
         hit_entry_s = push_entry_s;
      end else begin
         hit_s = hit_s;
      end
   end

`ifdef SB_FWD_EN
   assign fwd_s      = hit_s && fwd_covers(hit_entry_s.sh, hit_entry_s.byte_off[1],
                                           load_in.func3, load_addr[1]);
   assign load_ready = load_req && (!hit_s || fwd_s);
`else
   assign fwd_s      = 1'b0;
   assign load_ready = load_req && !hit_s;
`endif

   // A full buffer always drains, so a store arriving while full is never refused
   assign load_acc_s = load_ready;
   assign pop_s      = !sb_empty && (!load_acc_s || sb_full);
   assign push_s     = store_wb && (!sb_full || pop_s);
   assign wbe_s      = store_lanes(head_entry_s.sh, head_entry_s.byte_off[1]);

   // Store buffer entries, pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
         for (int i = 0; i < SB_DEPTH; i++) begin
            sb_r[i] <= '0;
         end
      end else begin
         if (pop_s) begin
            sb_r[head_r].valid <= 1'b0;
            head_r             <= head_r + PW'(1);
         end
         if (push_s) begin
            sb_r[tail_r] <= push_entry_s;
            tail_r       <= tail_r + PW'(1);
         end
         count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // Load response stage: result one cycle after acceptance
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_done    <= 1'b0;
         ld_pd      <= {PREG_W{1'b0}};
         ld_rob_tag <= {ROB_W{1'b0}};
         ld_f3_r    <= 3'b000;
         ld_off_r   <= 2'b00;
         ld_fwd_r   <= 1'b0;
         fwd_data_r <= 32'd0;
      end else begin
         ld_done <= load_acc_s;
         if (load_acc_s) begin
            ld_pd      <= load_in.pd;
            ld_rob_tag <= load_in.rob_index;
            ld_f3_r    <= load_in.func3;
            ld_off_r   <= load_addr[1:0];
            ld_fwd_r   <= fwd_s;
            fwd_data_r <= hit_entry_s.data;
         end
      end
   end

   assign ld_data = ld_done ? load_format(ld_f3_r, ld_fwd_r ? fwd_data_r : rdata_s, ld_off_r)
                            : 32'd0;

   dmem_store_drain_ram #(
      .MEM_WORDS (MEM_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (pop_s),
      .waddr (head_entry_s.word_idx[AW-1:0]),
      .wdata (head_entry_s.data),
      .wbe   (wbe_s),
      .re    (load_acc_s && !fwd_s),
      .raddr (ld_widx_s[AW-1:0]),
      .rdata (rdata_s)
   );

   logic unused_s;
   assign unused_s = ^{store_in.addr[31:AW+2], store_in.rob_tag, load_in.pc,
                       load_addr[31:AW+2], head_entry_s, hit_entry_s};

endmodule

// File: tb/tb_dmem_store_drain.sv
// Randomised scoreboard bench for dmem_store_drain against a queue/array reference model.
module tb_dmem_store_drain;
   import dmem_store_drain_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              store_wb;
   lsq_entry_t        store_in;
   logic              load_req;
   rs_data_t          load_in;
   logic [31:0]       load_addr;
   logic              load_ready;
   logic              ld_done;
   logic [31:0]       ld_data;
   logic [PREG_W-1:0] ld_pd;
   logic [ROB_W-1:0]  ld_rob_tag;
   logic              sb_full;
   logic              sb_empty;

   always #5 clk = ~clk;

   dmem_store_drain dut (
      .clk(clk), .reset(reset), .store_wb(store_wb), .store_in(store_in),
      .load_req(load_req), .load_in(load_in), .load_addr(load_addr),
      .load_ready(load_ready), .ld_done(ld_done), .ld_data(ld_data), .ld_pd(ld_pd),
      .ld_rob_tag(ld_rob_tag), .sb_full(sb_full), .sb_empty(sb_empty)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0]       data;
      logic [PREG_W-1:0] pd;
      logic [ROB_W-1:0]  tag;
   } exp_t;

   typedef struct {
      int       word;
      bit       sh;
      bit [1:0] off;
   } pend_t;

   exp_t        exp_q [$];
   pend_t       pend_q [$];
   logic [31:0] mem_m [int];
   exp_t        mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) & 32'd255);
   endfunction

   // Monitor: every load result is matched against the oldest expected response
   always @(negedge clk) begin
      if (reset && ld_done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ld_unexpected actual=%h required=none", ld_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("ld_data", ld_data, mon_e.data);
            chk("ld_pd", 32'(ld_pd), 32'(mon_e.pd));
            chk("ld_rob_tag", 32'(ld_rob_tag), 32'(mon_e.tag));
         end
      end
   end

   // One clock of stimulus plus model update
   task automatic cyc(input bit st, input logic [31:0] sa, input logic [31:0] sd, input bit ssh,
                      input bit ld, input logic [31:0] la, input logic [2:0] f3);
      int    lw_word;
      int    sw_word;
      bit    hit;
      bit    exp_rdy;
      bit    pop;
      pend_t y;
      exp_t  e;
      logic [31:0] w;
      @(posedge clk);
      #1;
      store_wb              = st;
      store_in.addr         = sa;
      store_in.ps2_data     = sd;
      store_in.sw_sh_signal = ssh;
      store_in.rob_tag      = ROB_W'($urandom);
      load_req              = ld;
      load_in.pc            = $urandom;
      load_in.pd            = PREG_W'($urandom);
      load_in.rob_index     = ROB_W'($urandom);
      load_in.func3         = f3;
      load_addr             = la;
      #1;
      chk("sb_full", 32'(sb_full), 32'(pend_q.size() == 4));
      chk("sb_empty", 32'(sb_empty), 32'(pend_q.size() == 0));
      lw_word = word_of(la);
      sw_word = word_of(sa);
      hit = 1'b0;
      y = '{0, 1'b0, 2'b00};
      foreach (pend_q[i]) begin
         if (pend_q[i].word == lw_word) begin
            hit = 1'b1;
            y = pend_q[i];
         end
      end
      if (st && sw_word == lw_word) begin
         hit = 1'b1;
         y = '{sw_word, ssh, sa[1:0]};
      end
      exp_rdy = ld && !hit;
`ifdef SB_FWD_EN
      exp_rdy = ld && (!hit || (f3 == F3_LW && !y.sh) ||
                       (f3 == F3_LBU && (!y.sh || y.off[1] == la[1])));
`endif
      chk("load_ready", 32'(load_ready), 32'(exp_rdy));
      if (exp_rdy) begin
         w = mem_m[lw_word];
         if (f3 == F3_LW) e.data = w;
         else if (f3 == F3_LBU) e.data = (w >> (8 * la[1:0])) & 32'h0000_00FF;
         else e.data = 32'd0;
         e.pd  = load_in.pd;
         e.tag = load_in.rob_index;
         exp_q.push_back(e);
      end
      pop = (pend_q.size() != 0) && (!exp_rdy || pend_q.size() == 4);
      if (pop) void'(pend_q.pop_front());
      if (st) begin
         pend_q.push_back('{sw_word, ssh, sa[1:0]});
         w = mem_m.exists(sw_word) ? mem_m[sw_word] : 32'd0;
         if (!ssh) w = sd;
         else if (sa[1]) w[31:16] = sd[15:0];
         else w[15:0] = sd[15:0];
         mem_m[sw_word] = w;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, F3_LW);
   endtask

   initial begin
      reset = 1'b0;
      store_wb = 1'b0; store_in = '0; load_req = 1'b0; load_in = '0; load_addr = 32'd0;
      #2;
      chk("rst_ld_done", 32'(ld_done), 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_ld_pd", 32'(ld_pd), 32'd0);
      chk("rst_ld_rob_tag", 32'(ld_rob_tag), 32'd0);
      chk("rst_sb_full", 32'(sb_full), 32'd0);
      chk("rst_sb_empty", 32'(sb_empty), 32'd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Known contents for the working window (words 16..31) and word 32
      for (int i = 16; i <= 32; i++) cyc(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, 32'd0, F3_LW);
      idle(3);

      // sw then lw of the same word: first attempt stalls, retry succeeds
      cyc(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, F3_LW);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h40, F3_LW);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h40, F3_LW);
      idle(2);
      // sh over sw
      cyc(1'b1, 32'h40, 32'h1122_3344, 1'b0, 1'b0, 32'd0, F3_LW);
      cyc(1'b1, 32'h42, 32'h0000_BEEF, 1'b1, 1'b0, 32'd0, F3_LW);
      idle(3);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h40, F3_LW);
      // load to buffered word stalls until drain
      cyc(1'b1, 32'h80, 32'hCAFE_F00D, 1'b0, 1'b0, 32'd0, F3_LW);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h80, F3_LW);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h80, F3_LW);
      // lbu of top byte
      cyc(1'b1, 32'h40, 32'hAABB_CCDD, 1'b0, 1'b0, 32'd0, F3_LW);
      idle(2);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h43, F3_LBU);
      idle(3);

      // Fill with continuous loads elsewhere, then a fifth store while full
      for (int i = 0; i < 5; i++)
         cyc(1'b1, 32'(32'h50 + 32'(i * 4)), $urandom, 1'b0, 1'b1, 32'h44, F3_LW);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h48, F3_LBU);
      idle(6);
      for (int i = 0; i < 5; i++)
         cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'(32'h50 + 32'(i * 4)), F3_LW);

      // Random traffic in a 16-word window with aliasing upper address bits
      for (int n = 0; n < 400; n++) begin
         bit st, ld, ssh;
         logic [31:0] sa, la;
         logic [2:0] f3;
         int r;
         st  = ($urandom_range(0, 99) < 40);
         ld  = ($urandom_range(0, 99) < 70);
         ssh = ($urandom_range(0, 99) < 30);
         sa  = 32'h40 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3))
               + (32'($urandom_range(0, 3)) << 10);
         la  = 32'h40 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3))
               + (32'($urandom_range(0, 3)) << 10);
         r   = $urandom_range(0, 2);
         f3  = (r == 0) ? F3_LW : ((r == 1) ? F3_LBU : 3'b001);
         cyc(st, sa, $urandom, ssh, ld, la, f3);
      end
      idle(8);

      // Reset with three buffered stores and a load result pending
      cyc(1'b1, 32'hC0, 32'h1111_1111, 1'b0, 1'b1, 32'h40, F3_LW);
      cyc(1'b1, 32'hC4, 32'h2222_2222, 1'b0, 1'b1, 32'h44, F3_LW);
      cyc(1'b1, 32'hC8, 32'h3333_3333, 1'b0, 1'b1, 32'h48, F3_LW);
      @(posedge clk);
      #1;
      store_wb = 1'b0;
      load_req = 1'b0;
      chk("pre_reset_sb_empty", 32'(sb_empty), 32'(pend_q.size() == 0));
      chk("pre_reset_ld_done", 32'(ld_done), 32'(exp_q.size() != 0));
      reset = 1'b0;
      #1;
      chk("mid_reset_sb_empty", 32'(sb_empty), 32'd1);
      chk("mid_reset_sb_full", 32'(sb_full), 32'd0);
      chk("mid_reset_ld_done", 32'(ld_done), 32'd0);
      chk("mid_reset_ld_data", ld_data, 32'd0);
      exp_q.delete();
      pend_q.delete();
      mem_m.delete(48);
      mem_m.delete(49);
      mem_m.delete(50);
      #2 reset = 1'b1;

      cyc(1'b1, 32'h100, 32'h0BAD_F00D, 1'b0, 1'b0, 32'd0, F3_LW);
      idle(2);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h100, F3_LW);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h103, F3_LBU);
      idle(4);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
